tt_serial_tx5: RTL and testbench
================================

# tt_serial_tx5

Fixed-frame asynchronous serial transmitter for the Tiny Tapeout 8-in/8-out user slot. The block detects a rising edge on a start pin, captures a 5-bit word from the remaining inputs, and shifts it out LSB-first on a single line as an idle-high frame: start bit, data, optional parity, stop bit(s). It is the transmit-side counterpart of the slot's edge-detecting input logic. It is intended to drive an external receiver or the companion receive slot.

## Interface
Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit, legal range 1..255.
- STOP_BITS, 1: number of stop bits, legal values 1 or 2.

Ports (module ports are io_in[7:0] and io_out[7:0], listed here by bit):
- io_in[0]  in  1  clock; all state changes on its rising edge; one clock only.
- io_in[1]  in  1  reset, synchronous, active-high.
- io_in[2]  in  1  start; a 0→1 transition requests a frame.
- io_in[7:3]  in  5  data word, sampled on the accepting edge.
- io_out[0]  out  1  tx serial line, idle high.
- io_out[1]  out  1  busy, high while a frame is in progress.
- io_out[2]  out  1  done, one-cycle pulse at frame end.
- io_out[7:3]  out  5  latched data word of the current or last frame.

## Operation
- All outputs are registered.
- Reset values: tx=1, busy=0, done=0, latched word=0, FSM=IDLE, bit/cycle counters=0.
- Start-edge register resets to 1, so a start pin held high through reset does not launch a frame.
- Edge detect: start_q <= io_in[2] every cycle. An edge is io_in[2]=1 && start_q=0.
- FSM states and transitions:
  - IDLE → START on an edge. On that edge: latch data into the shift register and io_out[7:3], set busy=1, set tx=0.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA sends 5 bits, LSB first, each held CLKS_PER_BIT cycles.
  - DATA → PARITY (macro defined) or → STOP.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP drives tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then → IDLE with busy=0 and done=1.
- done clears on the following edge.
- Frame length L = (1 + 5 + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 when parity is compiled in, else 0.
- Cycle counter width is 8 bits. The bit counter is 3 bits. No wrap occurs within legal parameter values.
- Start edges are ignored while busy=1, including the edge that returns to IDLE. start_q still tracks the pin, so the requester must drop and re-raise start.
- Data pins changing mid-frame have no effect; the word is captured only on the accepting edge.
- Reset asserted mid-frame: at the next edge the frame is abandoned and all reset values are restored. No partial stop bit is emitted; tx simply returns high.

## Timing
- Accepting edge N: after N, tx=0, busy=1, io_out[7:3]=word.
- Data bit k (k=0..4) is on tx during cycles after edges N+(1+k)*CLKS_PER_BIT through N+(2+k)*CLKS_PER_BIT-1.
- After edge N+L: busy=0, done=1, tx=1. After edge N+L+1: done=0.
- The earliest next accepting edge is N+L+1, giving back-to-back frames with no extra idle bit beyond the stop bit(s).
- Latency from start edge to the start bit on tx: 1 cycle (registered output).

## Configuration
- TX_PARITY_EN defined: a PARITY state after DATA drives the even-parity bit (XOR of the 5 latched bits) for CLKS_PER_BIT cycles.
- TX_PARITY_EN undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

## Test plan
- Reset with start held high, then release: no frame. tx=1, busy=0, done=0, io_out[7:3]=0 for 50 cycles.
- CLKS_PER_BIT=4, no parity, word 5'b10110, start edge at N:
  - tx bits, each 4 cycles: 0, 0,1,1,0,1, 1.
  - busy high for 28 cycles; done pulses once after edge N+28.
- Same word with TX_PARITY_EN: parity bit 1 appears after data bit 4; frame is 32 cycles; done after edge N+32.
- Second start edge at N+10 mid-frame: ignored, frame unchanged. A start rising at N+29 (after release low) launches a frame, with tx=0 after edge N+29.
- Reset asserted at N+12 during DATA: after next edge tx=1, busy=0, done=0, word=0. A subsequent start edge produces a full, correct frame.
- STOP_BITS=2, CLKS_PER_BIT=1, word 5'b11111: tx sequence 0,1,1,1,1,1,1,1. busy high for 8 cycles.

Source files
------------

// File: rtl/tt_serial_tx5.sv
// Edge-triggered 5-bit serial transmitter for the Tiny Tapeout 8-in/8-out slot.
// The even-parity bit after the data is compiled in only when TX_PARITY_EN is defined.
module tt_serial_tx5 #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    localparam logic [7:0] CYC_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0] DATA_LAST = 3'd4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] data;

    state_t     state;
    logic [7:0] cyc_cnt;
    logic [2:0] bit_cnt;
    logic [4:0] shift;
    logic [4:0] word;
    logic       tx;
    logic       busy;
    logic       done;
    logic       start_q;
    logic       start_edge;
    logic       bit_end;

    assign clk   = io_in[0];
    assign rst   = io_in[1];
    assign start = io_in[2];
    assign data  = io_in[7:3];

    assign start_edge = start & ~start_q;
    assign bit_end    = (cyc_cnt == CYC_LAST);

    assign io_out = {word, done, busy, tx};

    // Stop bits are counted with bit_cnt so cyc_cnt never has to span more than one bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            word    <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b1;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        shift   <= data;
                        word    <= data;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef TX_PARITY_EN
                            tx      <= ^word;
                            state   <= S_PARITY;
`else
                            tx      <= 1'b1;
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
`ifdef TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_serial_tx5.sv
// Scoreboard bench for tt_serial_tx5: one instance at 4 clocks/bit with 1 stop bit,
// one at 1 clock/bit with 2 stop bits. Expected tx streams are pushed at stimulus time.
module tb_tt_serial_tx5;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [4:0] data_a, data_b;
    logic [7:0] out_a, out_b;

    int errors = 0;
    int checks = 0;

`ifdef TX_PARITY_EN
    localparam int          NB_A = 8;
    localparam int          L_A  = 32;
    localparam logic [9:0]  SEQ1 = 10'b0011101100;  // word 10110, parity 1
    localparam logic [9:0]  SEQ2 = 10'b0010010010;  // word 01001, parity 0
    localparam logic [9:0]  SEQ3 = 10'b0011001110;  // word 00111, parity 1
    localparam int          NB_B = 9;
    localparam logic [9:0]  SEQB = 10'b0111111110;  // word 11111, parity 1, 2 stops
`else
    localparam int          NB_A = 7;
    localparam int          L_A  = 28;
    localparam logic [9:0]  SEQ1 = 10'b0001101100;  // word 10110
    localparam logic [9:0]  SEQ2 = 10'b0001010010;  // word 01001
    localparam logic [9:0]  SEQ3 = 10'b0001001110;  // word 00111
    localparam int          NB_B = 8;
    localparam logic [9:0]  SEQB = 10'b0011111110;  // word 11111, 2 stops
`endif

    tt_serial_tx5 #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .io_in  ({data_a, start_a, rst, clk}),
        .io_out (out_a)
    );

    tt_serial_tx5 #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_b (
        .io_in  ({data_b, start_b, rst, clk}),
        .io_out (out_b)
    );

    typedef struct packed {
        logic       d;
        logic       tx;
        logic [4:0] word;
    } exp_t;

    typedef struct packed {
        logic        d;
        logic [15:0] len;
    } len_t;

    exp_t exp_q[$];
    len_t len_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] outs(input int d);
        return (d == 0) ? out_a : out_b;
    endfunction

    task automatic push_frame(input logic d, input logic [4:0] w, input logic [9:0] seq,
                              input int nbits, input int cpb);
        exp_t e;
        len_t l;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                e.d    = d;
                e.tx   = seq[b];
                e.word = w;
                exp_q.push_back(e);
            end
        end
        l.d   = d;
        l.len = 16'(nbits * cpb);
        len_q.push_back(l);
    endtask

    task automatic wait_idle(input int d, input int limit);
        int n;
        n = 0;
        while (outs(d)[1] && n < limit) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, outs(d)[1]}, 32'd0);
    endtask

    // Monitor: pops one expected tx sample per busy cycle and one frame length per done pulse.
    bit   mon_en = 1'b0;
    int   blen [2];
    logic prev_done [2];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] o;
                exp_t       e;
                len_t       l;
                o = outs(d);
                if (o[1] === 1'b1) begin
                    blen[d]++;
                    if (exp_q.size() == 0) begin
                        chk("tx_unexpected_busy", 32'(d), 32'd9);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_dut", 32'(d), {31'd0, e.d});
                        chk("tx_bit", {31'd0, o[0]}, {31'd0, e.tx});
                        chk("word_out", {27'd0, o[7:3]}, {27'd0, e.word});
                    end
                end else begin
                    chk("idle_tx", {31'd0, o[0]}, 32'd1);
                end
                if (o[2] === 1'b1) begin
                    chk("done_single", {31'd0, prev_done[d]}, 32'd0);
                    if (len_q.size() == 0) begin
                        chk("done_unexpected", 32'(d), 32'd9);
                    end else begin
                        l = len_q.pop_front();
                        chk("done_dut", 32'(d), {31'd0, l.d});
                        chk("frame_len", 32'(blen[d]), {16'd0, l.len});
                    end
                end
                if (o[1] !== 1'b1) blen[d] = 0;
                prev_done[d] = o[2];
            end
        end
    end

    initial begin
        blen[0] = 0;
        blen[1] = 0;
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        rst     = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        data_a  = 5'b11111;
        data_b  = 5'b11111;
        repeat (3) tick();
        mon_en = 1'b1;

        // Start held high through and after reset must not launch a frame.
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("rst_tx",   {31'd0, out_a[0]}, 32'd1);
            chk("rst_busy", {31'd0, out_a[1]}, 32'd0);
            chk("rst_done", {31'd0, out_a[2]}, 32'd0);
            chk("rst_word", {27'd0, out_a[7:3]}, 32'd0);
            chk("rst_busy_b", {31'd0, out_b[1]}, 32'd0);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        tick();
        tick();

        // Frame 1 with a mid-frame start edge and data change, then back-to-back frame 2.
        data_a  = 5'b10110;
        start_a = 1'b1;
        push_frame(1'b0, 5'b10110, SEQ1, NB_A, 4);
        tick();
        chk("accept_busy", {31'd0, out_a[1]}, 32'd1);
        chk("accept_tx",   {31'd0, out_a[0]}, 32'd0);
        chk("accept_word", {27'd0, out_a[7:3]}, 32'b10110);
        for (int k = 1; k <= L_A + 1; k++) begin
            if (k == 4) start_a = 1'b0;
            if (k == 10) begin
                start_a = 1'b1;
                data_a  = 5'b00000;
            end
            if (k == 12) start_a = 1'b0;
            if (k == L_A + 1) begin
                start_a = 1'b1;
                data_a  = 5'b01001;
                push_frame(1'b0, 5'b01001, SEQ2, NB_A, 4);
            end
            tick();
            if (k == L_A) begin
                chk("end_done", {31'd0, out_a[2]}, 32'd1);
                chk("end_busy", {31'd0, out_a[1]}, 32'd0);
                chk("end_tx",   {31'd0, out_a[0]}, 32'd1);
            end
            if (k == L_A + 1) begin
                chk("b2b_done", {31'd0, out_a[2]}, 32'd0);
                chk("b2b_busy", {31'd0, out_a[1]}, 32'd1);
                chk("b2b_tx",   {31'd0, out_a[0]}, 32'd0);
                chk("b2b_word", {27'd0, out_a[7:3]}, 32'b01001);
            end
        end
        start_a = 1'b0;
        wait_idle(0, 100);
        tick();
        tick();

        // Frame abandoned by reset during DATA.
        data_a  = 5'b10110;
        start_a = 1'b1;
        push_frame(1'b0, 5'b10110, SEQ1, NB_A, 4);
        tick();
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) start_a = 1'b0;
            if (k == 12) rst = 1'b1;
            tick();
        end
        chk("abort_tx",   {31'd0, out_a[0]}, 32'd1);
        chk("abort_busy", {31'd0, out_a[1]}, 32'd0);
        chk("abort_done", {31'd0, out_a[2]}, 32'd0);
        chk("abort_word", {27'd0, out_a[7:3]}, 32'd0);
        exp_q.delete();
        len_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();

        data_a  = 5'b00111;
        start_a = 1'b1;
        push_frame(1'b0, 5'b00111, SEQ3, NB_A, 4);
        tick();
        chk("post_rst_busy", {31'd0, out_a[1]}, 32'd1);
        chk("post_rst_word", {27'd0, out_a[7:3]}, 32'b00111);
        start_a = 1'b0;
        wait_idle(0, 100);
        tick();
        tick();

        // One clock per bit with two stop bits.
        data_b  = 5'b11111;
        start_b = 1'b1;
        push_frame(1'b1, 5'b11111, SEQB, NB_B, 1);
        tick();
        chk("b_accept_busy", {31'd0, out_b[1]}, 32'd1);
        chk("b_accept_tx",   {31'd0, out_b[0]}, 32'd0);
        start_b = 1'b0;
        wait_idle(1, 50);
        tick();
        tick();

        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("len_drained", 32'(len_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
